// File: rtl/sos_lookahead.sv
// ============================================================================
// sos_lookahead : per-lane EB pre-decoder with 1-cycle COM/SOS look-ahead,
//                 COM window counter and SKP Ordered Set framing checker.
// Revision 1.0
// ============================================================================
`default_nettype none

module sos_lookahead #(
  parameter int SKP_MAX    = 5,
  parameter int LOCK_COUNT = 4
) (
  input  logic       clk_r_local,
  input  logic       rstn,
  input  logic [7:0] eb_data,
  input  logic       eb_is_k,
  input  logic       lock_clear,
  output logic [7:0] w_data,
  output logic       com_ahead,
  output logic       SOS_ahead,
  output logic [2:0] window_cnt,
  output logic       sos_err,
  output logic [2:0] skp_len
);

  localparam logic [7:0] COM_SYM   = 8'hBC;
  localparam logic [7:0] SKP_SYM   = 8'h1C;
  localparam logic [2:0] WIN_SAT   = 3'(LOCK_COUNT);
  localparam logic [3:0] SKP_LIMIT = 4'(SKP_MAX);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [7:0] s0_data;
  logic       s0_k;
  logic       skp_out;
  logic       s0_is_com;
  logic       s0_is_skp;
  logic       eb_is_skp;

  state_t     state, state_nxt;
  logic [2:0] skp_cnt, skp_cnt_nxt;
  logic [2:0] skp_len_nxt;
  logic [3:0] skp_inc;

  assign s0_is_com = (s0_data == COM_SYM) && s0_k;
  assign s0_is_skp = (s0_data == SKP_SYM) && s0_k;
  assign eb_is_skp = (eb_data == SKP_SYM) && eb_is_k;

  // SOS_ahead peeks at the symbol entering s0 so it lines up with its COM.
  always_ff @(posedge clk_r_local or negedge rstn) begin
    if (!rstn) begin
      s0_data   <= 8'h00;
      s0_k      <= 1'b0;
      w_data    <= 8'h00;
      com_ahead <= 1'b0;
      SOS_ahead <= 1'b0;
      skp_out   <= 1'b0;
    end else begin
      s0_data   <= eb_data;
      s0_k      <= eb_is_k;
      w_data    <= s0_data;
      com_ahead <= s0_is_com;
      SOS_ahead <= s0_is_com && eb_is_skp;
      skp_out   <= s0_is_skp;
    end
  end

  always_ff @(posedge clk_r_local or negedge rstn) begin
    if (!rstn) begin
      window_cnt <= 3'd0;
    end else if (lock_clear) begin
      window_cnt <= 3'd0;
    end else if (com_ahead && (window_cnt < WIN_SAT)) begin
      window_cnt <= window_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk_r_local or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      skp_cnt <= 3'd0;
      skp_len <= 3'd0;
    end else begin
      state   <= state_nxt;
      skp_cnt <= skp_cnt_nxt;
      skp_len <= skp_len_nxt;
    end
  end

  assign skp_inc = {1'b0, skp_cnt} + 4'd1;

  // sos_err is flagged while the offending SKP itself sits on w_data.
  always_comb begin
    state_nxt   = state;
    skp_cnt_nxt = skp_cnt;
    skp_len_nxt = skp_len;
    sos_err     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (SOS_ahead) begin
          state_nxt   = ST_RUN;
          skp_cnt_nxt = 3'd0;
        end else if (skp_out) begin
          sos_err = 1'b1;
        end
      end
      ST_RUN: begin
        if (skp_out) begin
          if (skp_inc > SKP_LIMIT) begin
            sos_err     = 1'b1;
            state_nxt   = ST_IDLE;
            skp_cnt_nxt = 3'd0;
          end else begin
            skp_cnt_nxt = skp_inc[2:0];
          end
        end else begin
          skp_len_nxt = skp_cnt;
          skp_cnt_nxt = 3'd0;
          state_nxt   = SOS_ahead ? ST_RUN : ST_IDLE;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        skp_cnt_nxt = 3'd0;
      end
    endcase
    if (lock_clear) begin
      state_nxt   = ST_IDLE;
      skp_cnt_nxt = 3'd0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sos_lookahead.sv
// Self-checking bench for sos_lookahead: delay-line scoreboard on the symbol
// stream plus per-scenario checks of window_cnt, skp_len and sos_err.
`default_nettype none

module tb_sos_lookahead;

  logic       clk_r_local = 1'b0;
  logic       rstn;
  logic [7:0] eb_data;
  logic       eb_is_k;
  logic       lock_clear;
  logic [7:0] w_data;
  logic       com_ahead;
  logic       SOS_ahead;
  logic [2:0] window_cnt;
  logic       sos_err;
  logic [2:0] skp_len;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       com;
    logic       sos;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] prev_d;
  logic       prev_k;

  always #5 clk_r_local = ~clk_r_local;

  sos_lookahead #(.SKP_MAX(5), .LOCK_COUNT(4)) dut (
    .clk_r_local (clk_r_local),
    .rstn        (rstn),
    .eb_data     (eb_data),
    .eb_is_k     (eb_is_k),
    .lock_clear  (lock_clear),
    .w_data      (w_data),
    .com_ahead   (com_ahead),
    .SOS_ahead   (SOS_ahead),
    .window_cnt  (window_cnt),
    .sos_err     (sos_err),
    .skp_len     (skp_len)
  );

  // Drive one symbol; the symbol driven one step earlier is expected on
  // w_data after this edge, with its SOS flag decided by this new symbol.
  task automatic step(input logic [7:0] d, input logic k, input logic clr);
    exp_t e;
    e.data = prev_d;
    e.com  = (prev_d == 8'hBC) && prev_k;
    e.sos  = e.com && (d == 8'h1C) && k;
    sb.push_back(e);
    eb_data    = d;
    eb_is_k    = k;
    lock_clear = clr;
    @(posedge clk_r_local);
    #1;
    e = sb.pop_front();
    checks++;
    if (w_data !== e.data || com_ahead !== e.com || SOS_ahead !== e.sos) begin
      errors++;
      $display("FAIL stream: got w_data=%h com=%b sos=%b, expected w_data=%h com=%b sos=%b",
               w_data, com_ahead, SOS_ahead, e.data, e.com, e.sos);
    end
    prev_d = d;
    prev_k = k;
  endtask

  task automatic test_reset();
    rstn       = 1'b0;
    eb_data    = 8'h00;
    eb_is_k    = 1'b0;
    lock_clear = 1'b0;
    prev_d     = 8'h00;
    prev_k     = 1'b0;
    repeat (2) @(posedge clk_r_local);
    #1;
    checks++;
    if ({w_data, com_ahead, SOS_ahead, window_cnt, sos_err, skp_len} !== 16'h0000) begin
      errors++;
      $display("FAIL reset: got w=%h com=%b sos=%b win=%0d err=%b len=%0d, expected all 0",
               w_data, com_ahead, SOS_ahead, window_cnt, sos_err, skp_len);
    end
    rstn = 1'b1;
  endtask

  task automatic test_sos_basic();
    logic [7:0] d [8] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h4A, 8'h00, 8'h00, 8'h00};
    logic       k [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(d[i], k[i], 1'b0);
      checks++;
      if (sos_err !== 1'b0) begin
        errors++;
        $display("FAIL basic_err step %0d: got %b, expected 0", i, sos_err);
      end
      if (i == 1) begin
        checks++;
        if (w_data !== 8'hBC || com_ahead !== 1'b1 || SOS_ahead !== 1'b1) begin
          errors++;
          $display("FAIL basic_com: got w=%h com=%b sos=%b, expected BC 1 1",
                   w_data, com_ahead, SOS_ahead);
        end
      end
      if (i == 5 || i == 6) begin
        checks++;
        if (skp_len !== ((i == 6) ? 3'd3 : 3'd0)) begin
          errors++;
          $display("FAIL basic_len step %0d: got %0d, expected %0d", i, skp_len,
                   (i == 6) ? 3 : 0);
        end
      end
    end
  endtask

  task automatic test_window();
    step(8'h00, 1'b0, 1'b1);
    checks++;
    if (window_cnt !== 3'd0) begin
      errors++;
      $display("FAIL window_clear: got %0d, expected 0", window_cnt);
    end
    for (int c = 0; c < 5; c++) begin
      step(8'hBC, 1'b1, 1'b0);
      for (int j = 0; j < 15; j++) begin
        step(8'h40 + 8'(j), 1'b0, 1'b0);
        checks++;
        if (sos_err !== 1'b0) begin
          errors++;
          $display("FAIL window_err com %0d sym %0d: got %b, expected 0", c, j, sos_err);
        end
        if (j == 0) begin
          checks++;
          if (window_cnt !== 3'((c > 4) ? 4 : c)) begin
            errors++;
            $display("FAIL window_pre com %0d: got %0d, expected %0d", c, window_cnt,
                     (c > 4) ? 4 : c);
          end
        end
        if (j == 1) begin
          checks++;
          if (window_cnt !== 3'((c + 1 > 4) ? 4 : c + 1)) begin
            errors++;
            $display("FAIL window_post com %0d: got %0d, expected %0d", c, window_cnt,
                     (c + 1 > 4) ? 4 : c + 1);
          end
        end
      end
    end
  endtask

  task automatic test_skp_overflow();
    logic [7:0] d [11] = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C,
                           8'h4A, 8'h00, 8'h00, 8'h00};
    logic       k [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                           1'b0, 1'b0, 1'b0, 1'b0};
    int pulses = 0;
    for (int i = 0; i < 11; i++) begin
      step(d[i], k[i], 1'b0);
      if (sos_err === 1'b1) pulses++;
      checks++;
      if (sos_err !== (i == 7)) begin
        errors++;
        $display("FAIL overflow_err step %0d: got %b, expected %b", i, sos_err, (i == 7));
      end
      if (i >= 9) begin
        checks++;
        if (skp_len !== 3'd3) begin
          errors++;
          $display("FAIL overflow_len step %0d: got %0d, expected 3", i, skp_len);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL overflow_pulses: got %0d, expected 1", pulses);
    end
  endtask

  task automatic test_d28_and_stray();
    logic [7:0] d [8] = '{8'h4A, 8'h1C, 8'h4A, 8'h00, 8'h1C, 8'h4A, 8'h00, 8'h00};
    logic       k [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      step(d[i], k[i], 1'b0);
      checks++;
      if (sos_err !== (i == 5)) begin
        errors++;
        $display("FAIL stray_err step %0d: got %b, expected %b", i, sos_err, (i == 5));
      end
      if (i == 2) begin
        checks++;
        if (w_data !== 8'h1C || com_ahead !== 1'b0) begin
          errors++;
          $display("FAIL d28: got w=%h com=%b, expected 1C 0", w_data, com_ahead);
        end
      end
    end
  endtask

  task automatic test_clear_priority();
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(8'hBC, 1'b1, 1'b0);
      step(8'h4A, 1'b0, 1'b0);
    end
    checks++;
    if (window_cnt !== 3'd3 || com_ahead !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: got win=%0d com=%b, expected 3 1", window_cnt, com_ahead);
    end
    step(8'h4A, 1'b0, 1'b1);
    checks++;
    if (window_cnt !== 3'd0) begin
      errors++;
      $display("FAIL clear_priority: got %0d, expected 0", window_cnt);
    end
    step(8'h4A, 1'b0, 1'b0);
    checks++;
    if (window_cnt !== 3'd0) begin
      errors++;
      $display("FAIL clear_hold: got %0d, expected 0", window_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [8] = '{8'hBC, 8'h1C, 8'hBC, 8'h1C, 8'h1C, 8'h00, 8'h00, 8'h00};
    logic       k [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0] len_exp [8] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd1, 3'd1, 3'd1, 3'd2};
    for (int i = 0; i < 8; i++) begin
      step(d[i], k[i], 1'b0);
      checks++;
      if (sos_err !== 1'b0 || skp_len !== len_exp[i]) begin
        errors++;
        $display("FAIL b2b step %0d: got err=%b len=%0d, expected err=0 len=%0d",
                 i, sos_err, skp_len, len_exp[i]);
      end
      if (i == 3) begin
        checks++;
        if (w_data !== 8'hBC || SOS_ahead !== 1'b1) begin
          errors++;
          $display("FAIL b2b_second_sos: got w=%h sos=%b, expected BC 1", w_data, SOS_ahead);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sos();
    step(8'hBC, 1'b1, 1'b0);
    step(8'h1C, 1'b1, 1'b0);
    step(8'h1C, 1'b1, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({w_data, com_ahead, SOS_ahead, window_cnt, sos_err, skp_len} !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: got w=%h com=%b sos=%b win=%0d err=%b len=%0d, expected all 0",
               w_data, com_ahead, SOS_ahead, window_cnt, sos_err, skp_len);
    end
    repeat (2) @(posedge clk_r_local);
    #1;
    rstn   = 1'b1;
    prev_d = 8'h00;
    prev_k = 1'b0;
    step(8'h1C, 1'b1, 1'b0);
    checks++;
    if (sos_err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_0: got %b, expected 0", sos_err);
    end
    step(8'h4A, 1'b0, 1'b0);
    checks++;
    if (sos_err !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_stray: got %b, expected 1", sos_err);
    end
    step(8'h00, 1'b0, 1'b0);
    checks++;
    if (sos_err !== 1'b0 || skp_len !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_tail: got err=%b len=%0d, expected 0 0", sos_err, skp_len);
    end
  endtask

  initial begin
    test_reset();
    test_sos_basic();
    test_window();
    test_skp_overflow();
    test_d28_and_stray();
    test_clear_priority();
    test_back_to_back();
    test_reset_mid_sos();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sos_lookahead.md
Name: sos_lookahead

Overview:
- Per-lane symbol pre-decoder between the elastic buffer (EB) output and the deskew FIFO.
- Delays the EB symbol stream by two cycles and flags each outgoing symbol with one cycle of look-ahead:
  - COM detection.
  - SKP Ordered Set (SOS) detection.
  - The "count 4" COM window counter that enables deskew.
- Also checks SOS framing (SKP run length, stray SKPs) and reports violations.

Parameters:
- SKP_MAX, 5, maximum number of SKP symbols legally following the COM of one SOS (range 1..7).
- LOCK_COUNT, 4, number of COMs needed before window_cnt[2] asserts; fixed at 4 in this revision (window_cnt saturates at 3'd4).

Ports:
- clk_r_local  input  1  local recovered-clock domain of this lane; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- eb_data  input  8  decoded symbol from EB, one per cycle.
- eb_is_k  input  1  eb_data is a K (control) character.
- lock_clear  input  1  synchronous clear of window counter and SOS checker (link retrain).
- w_data  output  8  delayed symbol to deskew FIFO.
- com_ahead  output  1  w_data is COM (K28.5, 8'hBC, is_k=1).
- SOS_ahead  output  1  w_data is the COM that starts an SOS.
- window_cnt  output  3  COMs seen since reset/clear, saturating at 4.
- sos_err  output  1  one-cycle pulse on an SOS framing violation.
- skp_len  output  3  SKP count of the most recently completed SOS.

Behaviour:
- Reset (rstn low, async) clears all registers:
  - w_data=8'h00; com_ahead=0; SOS_ahead=0; window_cnt=0; sos_err=0; skp_len=0.
  - Internal stage s0 cleared to data 8'h00, k=0; FSM=IDLE; skp_cnt=0.
- Decodes: COM = (data==8'hBC && k). SKP = (data==8'h1C && k). D-characters never match.
- Pipeline: every edge s0 <= {eb_data, eb_is_k}, and the output registers load from s0:
  - w_data <= s0.data.
  - com_ahead <= COM(s0).
  - SOS_ahead <= COM(s0) && SKP(eb_data, eb_is_k), i.e. look-ahead at the symbol entering s0.
  - Latency from EB input to w_data is exactly 2 cycles. No stalls; one symbol per cycle.
- SOS_ahead is never 1 while com_ahead is 0. SKP symbols themselves carry SOS_ahead=0; the deskew FIFO drops them by value.
- window_cnt: increments on every cycle with com_ahead=1 (including SOS COMs) while < 4, then holds at 4.
  - lock_clear=1 forces window_cnt to 0 at the next edge, taking priority over a simultaneous increment.
- SOS checker FSM, evaluated on the output-stage flags:
  - IDLE: SOS_ahead=1 -> RUN, skp_cnt=0. Output SKP in IDLE (stray SKP) -> sos_err pulse, stay IDLE.
  - RUN: output SKP -> skp_cnt+1. If skp_cnt+1 > SKP_MAX -> sos_err pulse, go IDLE, skp_cnt=0.
  - RUN: first non-SKP -> skp_len <= skp_cnt, go IDLE. If that symbol is itself an SOS COM, re-enter RUN with skp_cnt=0; back-to-back SOS is legal.
- sos_err is a single-cycle pulse and never asserts twice for the same symbol.
- lock_clear also forces FSM=IDLE and skp_cnt=0. It does not flush the data pipeline.
- Reset mid-SOS: all state cleared immediately. Symbols after release are treated as fresh; a leading stray SKP raises sos_err.

Test Plan:
- Reset release, EB stream BC/k, 1C/k, 1C/k, 1C/k, 4A/d -> w_data shows BC two cycles after input with com_ahead=1 and SOS_ahead=1; skp_len=3 one cycle after 4A appears at w_data; sos_err stays 0.
- Four TS1 COMs (BC/k followed by 15 D-symbols each) -> window_cnt steps 1,2,3,4 and holds 4 on a fifth COM; SOS_ahead stays 0 throughout.
- SOS with 6 SKPs, SKP_MAX=5 -> sos_err pulses exactly once, when the 6th SKP is at w_data; the trailing symbol does not update skp_len.
- 1C with is_k=0 (D28.0) mid-packet -> no sos_err, com_ahead=0; 1C/k outside an SOS -> one sos_err pulse.
- lock_clear asserted in the same cycle com_ahead=1 with window_cnt=3 -> window_cnt becomes 0, not 4.
- Back-to-back SOS: BC,1C,BC,1C,1C,00 (k on all but 00) -> SOS_ahead on both COMs; skp_len becomes 1, then 2; no error; rstn pulsed low mid-run -> all outputs 0 asynchronously.
